// File: rtl/bif_bctl_pkg.sv
// Shared types and defaults for the BIF bus-control arbiter: FSM states,
// requester identities and the grant decode used by the top level.
package bif_bctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REF   = 3'd1,
    ST_GRANT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_REC   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OWN_REF = 2'd0,
    OWN_SEM = 2'd1,
    OWN_BUS = 2'd2,
    OWN_CPU = 2'd3
  } owner_e;

  localparam int REF_CYC_DEF = 4;
  localparam int TMO_CYC_DEF = 255;
  localparam int TMO_W_DEF   = 8;

  // Active-low grant vector {REF, SEM, BUS, CPU}; at most one bit is ever low.
  function automatic logic [3:0] grant_vec(input state_e st, input owner_e own);
    logic [3:0] g;
    g = 4'b1111;
    if (st == ST_REF) begin
      g[3] = 1'b0;
    end else if ((st == ST_GRANT) || (st == ST_WAIT)) begin
      case (own)
        OWN_SEM: g[2] = 1'b0;
        OWN_BUS: g[1] = 1'b0;
        OWN_CPU: g[0] = 1'b0;
        default: g    = 4'b1111;
      endcase
    end else begin
      g = 4'b1111;
    end
    return g;
  endfunction

endpackage

// File: rtl/bif_bctl_tmo.sv
// Loadable up-counter with a terminal flag; shared by the refresh hold
// length and the data-ready timeout in the arbiter.
module bif_bctl_tmo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // load wins over count; counter idles at zero outside counted states
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Set during the cycle whose increment would reach the limit.
  assign last = (cnt_q == (limit - W'(1)));

endmodule

// File: rtl/bif_bctl_arb.sv
// BIF bus-control arbiter: grants one of refresh/semaphore/bus/CPU at a time,
// waits for data-ready and reports cycle end, timeout and parity error.
module bif_bctl_arb
  import bif_bctl_pkg::*;
#(
  parameter int REF_CYC = REF_CYC_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF,
  parameter int TMO_W   = TMO_W_DEF
) (
  input  logic OSC,
  input  logic CLEAR,
  input  logic REFRQ50_n,
  input  logic SEMRQ50_n,
  input  logic BREQ50_n,
  input  logic CREQ_n,
  input  logic BDRY50_n,
  input  logic BPERR50_n,
  input  logic BLOCK25_n,
  output logic REFGNT_n,
  output logic SEMGNT_n,
  output logic BGNT_n,
  output logic CGNT_n,
  output logic CYCEND_n,
  output logic BERR_n,
  output logic PERR_n,
  output logic BUSY_n
);

  localparam logic [TMO_W-1:0] REF_LIM = TMO_W'(REF_CYC);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       fair_q, fair_d;   // 1: CPU wins the next BUS/CPU contest
  logic [3:0] gnt_q, gnt_d;
  logic       cycend_q, cycend_d;
  logic       berr_q, berr_d;
  logic       perr_q, perr_d;
  logic       busy_q, busy_d;

  logic             tmo_load_s;
  logic             tmo_en_s;
  logic             tmo_last_s;
  logic [TMO_W-1:0] tmo_limit_s;
  logic             own_req_s;

  // One counter serves both REF hold and WAIT timeout; cleared everywhere else
  always_comb begin
    tmo_load_s  = 1'b1;
    tmo_en_s    = 1'b0;
    tmo_limit_s = TMO_LIM;
    if (state_q == ST_REF) begin
      tmo_load_s  = 1'b0;
      tmo_en_s    = 1'b1;
      tmo_limit_s = REF_LIM;
    end else if (state_q == ST_WAIT) begin
      tmo_load_s  = 1'b0;
      tmo_en_s    = BDRY50_n;
      tmo_limit_s = TMO_LIM;
    end else begin
      tmo_load_s  = 1'b1;
      tmo_en_s    = 1'b0;
      tmo_limit_s = TMO_LIM;
    end
  end

  bif_bctl_tmo #(
    .W (TMO_W)
  ) u_tmo (
    .clk   (OSC),
    .clr   (CLEAR),
    .load  (tmo_load_s),
    .en    (tmo_en_s),
    .limit (tmo_limit_s),
    .last  (tmo_last_s)
  );

  // Is the current owner still requesting (used for locked re-grant)
  always_comb begin
    own_req_s = 1'b0;
    case (owner_q)
      OWN_SEM: own_req_s = ~SEMRQ50_n;
      OWN_BUS: own_req_s = ~BREQ50_n;
      OWN_CPU: own_req_s = ~CREQ_n;
      default: own_req_s = 1'b0;
    endcase
  end

  // Next-state, arbitration and fairness update
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    fair_d  = fair_q;
    case (state_q)
      ST_IDLE: begin
        if (!REFRQ50_n) begin
          state_d = ST_REF;
          owner_d = OWN_REF;
        end else if (!SEMRQ50_n) begin
          state_d = ST_GRANT;
          owner_d = OWN_SEM;
        end else if (!BREQ50_n && !CREQ_n) begin
          state_d = ST_GRANT;
          owner_d = fair_q ? OWN_CPU : OWN_BUS;
          fair_d  = ~fair_q;
        end else if (!BREQ50_n) begin
          state_d = ST_GRANT;
          owner_d = OWN_BUS;
        end else if (!CREQ_n) begin
          state_d = ST_GRANT;
          owner_d = OWN_CPU;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REF: begin
        if (tmo_last_s) begin
          state_d = ST_REC;
        end else begin
          state_d = ST_REF;
        end
      end
      ST_GRANT: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Data ready takes precedence over a coincident timeout.
        if (!BDRY50_n) begin
          state_d = ST_REC;
        end else if (tmo_last_s) begin
          state_d = ST_REC;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_REC: begin
        if (!BLOCK25_n && (owner_q != OWN_REF) && own_req_s) begin
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode, registered so pins line up with the state register
  always_comb begin
    gnt_d    = grant_vec(state_d, owner_d);
    busy_d   = (state_d == ST_IDLE);
    cycend_d = 1'b1;
    perr_d   = 1'b1;
    berr_d   = 1'b1;
    if (state_q == ST_WAIT) begin
      if (!BDRY50_n) begin
        cycend_d = 1'b0;
        perr_d   = BPERR50_n;
      end else begin
        berr_d   = ~tmo_last_s;
      end
    end else begin
      cycend_d = 1'b1;
    end
  end

  // State, owner, fairness and output registers
  always_ff @(posedge OSC) begin
    if (CLEAR) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_CPU;
      fair_q   <= 1'b1;
      gnt_q    <= 4'b1111;
      cycend_q <= 1'b1;
      berr_q   <= 1'b1;
      perr_q   <= 1'b1;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      fair_q   <= fair_d;
      gnt_q    <= gnt_d;
      cycend_q <= cycend_d;
      berr_q   <= berr_d;
      perr_q   <= perr_d;
      busy_q   <= busy_d;
    end
  end

  assign REFGNT_n = gnt_q[3];
  assign SEMGNT_n = gnt_q[2];
  assign BGNT_n   = gnt_q[1];
  assign CGNT_n   = gnt_q[0];
  assign CYCEND_n = cycend_q;
  assign BERR_n   = berr_q;
  assign PERR_n   = perr_q;
  assign BUSY_n   = busy_q;

endmodule

// File: tb/tb_bif_bctl_arb.sv
// Directed bench for bif_bctl_arb. Outputs are compared as one byte
// {REFGNT,SEMGNT,BGNT,CGNT,CYCEND,BERR,PERR,BUSY}, sampled on the falling edge.
module tb_bif_bctl_arb;

  logic OSC = 1'b0;
  logic CLEAR = 1'b1;
  logic REFRQ50_n = 1'b1;
  logic SEMRQ50_n = 1'b1;
  logic BREQ50_n = 1'b1;
  logic CREQ_n = 1'b1;
  logic BDRY50_n = 1'b1;
  logic BPERR50_n = 1'b1;
  logic BLOCK25_n = 1'b1;
  logic REFGNT_n, SEMGNT_n, BGNT_n, CGNT_n;
  logic CYCEND_n, BERR_n, PERR_n, BUSY_n;
  logic [7:0] outs_s;

  int compared = 0;
  int mismatched = 0;

  // Expected output bytes
  localparam logic [7:0] O_IDLE = 8'hFF;
  localparam logic [7:0] O_REF  = 8'h7E;
  localparam logic [7:0] O_SEM  = 8'hBE;
  localparam logic [7:0] O_BUS  = 8'hDE;
  localparam logic [7:0] O_CPU  = 8'hEE;
  localparam logic [7:0] O_REC  = 8'hFE;
  localparam logic [7:0] O_END  = 8'hF6;
  localparam logic [7:0] O_PER  = 8'hF4;
  localparam logic [7:0] O_TMO  = 8'hFA;

  always #5 OSC = ~OSC;

  assign outs_s = {REFGNT_n, SEMGNT_n, BGNT_n, CGNT_n, CYCEND_n, BERR_n, PERR_n, BUSY_n};

  bif_bctl_arb dut (
    .OSC       (OSC),
    .CLEAR     (CLEAR),
    .REFRQ50_n (REFRQ50_n),
    .SEMRQ50_n (SEMRQ50_n),
    .BREQ50_n  (BREQ50_n),
    .CREQ_n    (CREQ_n),
    .BDRY50_n  (BDRY50_n),
    .BPERR50_n (BPERR50_n),
    .BLOCK25_n (BLOCK25_n),
    .REFGNT_n  (REFGNT_n),
    .SEMGNT_n  (SEMGNT_n),
    .BGNT_n    (BGNT_n),
    .CGNT_n    (CGNT_n),
    .CYCEND_n  (CYCEND_n),
    .BERR_n    (BERR_n),
    .PERR_n    (PERR_n),
    .BUSY_n    (BUSY_n)
  );

  task automatic step();
    @(negedge OSC);
  endtask

  task automatic test_reset();
    CLEAR = 1'b1;
    CREQ_n = 1'b0;
    step();
    step();
    compared++;
    if (outs_s !== O_IDLE) begin
      mismatched++;
      $display("FAIL reset outs=%h expected=%h", outs_s, O_IDLE);
    end
    CLEAR = 1'b0;
    CREQ_n = 1'b1;
    step();
    compared++;
    if (outs_s !== O_IDLE) begin
      mismatched++;
      $display("FAIL reset_idle outs=%h expected=%h", outs_s, O_IDLE);
    end
  endtask

  task automatic test_cpu_cycle();
    logic [7:0] exp_t [7];
    exp_t = '{O_CPU, O_CPU, O_CPU, O_CPU, O_CPU, O_END, O_IDLE};
    CREQ_n = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      compared++;
      if (outs_s !== exp_t[i]) begin
        mismatched++;
        $display("FAIL cpu_cycle[%0d] outs=%h expected=%h", i, outs_s, exp_t[i]);
      end
      if (i == 4) BDRY50_n = 1'b0;
      if (i == 5) begin
        BDRY50_n = 1'b1;
        CREQ_n = 1'b1;
      end
    end
  endtask

  task automatic test_priority();
    logic [7:0] exp_t [22];
    exp_t = '{O_REF, O_REF, O_REF, O_REF, O_REC, O_IDLE,
              O_SEM, O_SEM, O_END, O_IDLE,
              O_CPU, O_CPU, O_END, O_IDLE,
              O_BUS, O_BUS, O_END, O_IDLE,
              O_CPU, O_CPU, O_END, O_IDLE};
    REFRQ50_n = 1'b0;
    SEMRQ50_n = 1'b0;
    BREQ50_n = 1'b0;
    CREQ_n = 1'b0;
    BDRY50_n = 1'b0;
    for (int i = 0; i < 22; i++) begin
      step();
      compared++;
      if (outs_s !== exp_t[i]) begin
        mismatched++;
        $display("FAIL priority[%0d] outs=%h expected=%h", i, outs_s, exp_t[i]);
      end
      if (i == 0) REFRQ50_n = 1'b1;
      if (i == 6) SEMRQ50_n = 1'b1;
      if (i == 18) begin
        BREQ50_n = 1'b1;
        CREQ_n = 1'b1;
      end
    end
    BDRY50_n = 1'b1;
  endtask

  task automatic test_lock();
    logic [7:0] exp_t [11];
    exp_t = '{O_BUS, O_BUS, O_END, O_BUS, O_BUS, O_END, O_IDLE,
              O_CPU, O_CPU, O_END, O_IDLE};
    BREQ50_n = 1'b0;
    CREQ_n = 1'b0;
    BLOCK25_n = 1'b0;
    BDRY50_n = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      compared++;
      if (outs_s !== exp_t[i]) begin
        mismatched++;
        $display("FAIL lock[%0d] outs=%h expected=%h", i, outs_s, exp_t[i]);
      end
      if (i == 4) BLOCK25_n = 1'b1;
      if (i == 9) begin
        BREQ50_n = 1'b1;
        CREQ_n = 1'b1;
      end
    end
    BDRY50_n = 1'b1;
  endtask

  task automatic test_parity();
    logic [7:0] exp_t [4];
    exp_t = '{O_BUS, O_BUS, O_PER, O_IDLE};
    BREQ50_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      compared++;
      if (outs_s !== exp_t[i]) begin
        mismatched++;
        $display("FAIL parity[%0d] outs=%h expected=%h", i, outs_s, exp_t[i]);
      end
      if (i == 0) begin
        BDRY50_n = 1'b0;
        BPERR50_n = 1'b0;
      end
      if (i == 2) begin
        BREQ50_n = 1'b1;
        BDRY50_n = 1'b1;
        BPERR50_n = 1'b1;
      end
    end
  endtask

  task automatic test_timeout();
    int held;
    BREQ50_n = 1'b0;
    step();
    compared++;
    if (outs_s !== O_BUS) begin
      mismatched++;
      $display("FAIL timeout_grant outs=%h expected=%h", outs_s, O_BUS);
    end
    // withdrawn request must not abort the cycle
    BREQ50_n = 1'b1;
    held = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (outs_s !== O_BUS) break;
      held++;
    end
    compared++;
    if (held !== 256) begin
      mismatched++;
      $display("FAIL timeout_len grant_cycles=%0d expected=%0d", held, 256);
    end
    compared++;
    if (outs_s !== O_TMO) begin
      mismatched++;
      $display("FAIL timeout_berr outs=%h expected=%h", outs_s, O_TMO);
    end
    step();
    compared++;
    if (outs_s !== O_IDLE) begin
      mismatched++;
      $display("FAIL timeout_idle outs=%h expected=%h", outs_s, O_IDLE);
    end
  endtask

  task automatic test_clear_midcycle();
    logic [7:0] exp_t [7];
    exp_t = '{O_BUS, O_BUS, O_IDLE, O_CPU, O_CPU, O_END, O_IDLE};
    BREQ50_n = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      compared++;
      if (outs_s !== exp_t[i]) begin
        mismatched++;
        $display("FAIL clear[%0d] outs=%h expected=%h", i, outs_s, exp_t[i]);
      end
      if (i == 1) begin
        CLEAR = 1'b1;
        BDRY50_n = 1'b0;
      end
      if (i == 2) begin
        CLEAR = 1'b0;
        CREQ_n = 1'b0;
      end
      if (i == 5) begin
        BREQ50_n = 1'b1;
        CREQ_n = 1'b1;
        BDRY50_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_cycle();
    test_priority();
    test_lock();
    test_parity();
    test_timeout();
    test_clear_midcycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
